attack_ctrl: RTL

ATTACK_CTRL -- requirements
Module: attack_ctrl

---
 rtl/attack_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/attack_ctrl.sv
// Melee attack sequencer: windup, strike, cooldown and release for one player.
// Drives level hit/block strobes to the opponent health bar and counts landed strikes.
module attack_ctrl #(
  parameter int unsigned WINDUP_CYC   = 4,
  parameter int unsigned STRIKE_CYC   = 3,
  parameter int unsigned COOLDOWN_CYC = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       attack,
  input  logic       in_range,
  input  logic       opp_blocking,
  input  logic       self_death,
  input  logic       other_death,
  output logic       hit,
  output logic       block,
  output logic       busy,
  output logic [7:0] hit_count
);

  localparam int unsigned MAX_WS  = (WINDUP_CYC > STRIKE_CYC) ? WINDUP_CYC : STRIKE_CYC;
  localparam int unsigned MAX_CYC = (MAX_WS > COOLDOWN_CYC) ? MAX_WS : COOLDOWN_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] WINDUP_LD   = CNT_W'(WINDUP_CYC - 1);
  localparam logic [CNT_W-1:0] STRIKE_LD   = CNT_W'(STRIKE_CYC - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LD = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WINDUP,
    S_STRIKE,
    S_RECOVER,
    S_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    OC_MISS = 2'd0,
    OC_HIT  = 2'd1,
    OC_BLK  = 2'd2
  } outcome_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  outcome_t         r_outcome;
  outcome_t         w_outcome_nxt;
  logic [7:0]       r_hit_count;
  logic             w_hit_land;
  logic             w_death;

  assign w_death = self_death | other_death;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_outcome <= OC_MISS;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_outcome <= w_outcome_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_outcome_nxt = r_outcome;
    w_hit_land    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (attack && !w_death) begin
          w_state_nxt = S_WINDUP;
          w_cnt_nxt   = WINDUP_LD;
        end
      end
      S_WINDUP: begin
        // A death on the final windup cycle aborts before the outcome latches,
        // so the strike never begins and nothing is counted.
        if (w_death) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_STRIKE;
          w_cnt_nxt   = STRIKE_LD;
          if (!in_range) begin
            w_outcome_nxt = OC_MISS;
          end else if (opp_blocking) begin
            w_outcome_nxt = OC_BLK;
          end else begin
            w_outcome_nxt = OC_HIT;
            w_hit_land    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_STRIKE: begin
        if (w_death) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = COOLDOWN_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_RECOVER: begin
        if (w_death || (r_cnt == '0)) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (!attack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hit_count <= '0;
    end else if (w_hit_land && (r_hit_count != '1)) begin
      r_hit_count <= r_hit_count + 8'd1;
    end
  end

  // Decoded purely from registered state so reset clears them without a clock edge.
  assign hit       = (r_state == S_STRIKE) && (r_outcome == OC_HIT);
  assign block     = (r_state == S_STRIKE) && (r_outcome == OC_BLK);
  assign busy      = (r_state != S_IDLE);
  assign hit_count = r_hit_count;

endmodule
